// File: rtl/fixedpoint_divider.sv
// Sequential signed fixed-point divider: restoring shift-subtract,
// one quotient bit per clock, saturated Q(WIO.WFO) result.
module fixedpoint_divider #(
    parameter int WI1 = 4,
    parameter int WF1 = 5,
    parameter int WI2 = 3,
    parameter int WF2 = 3,
    parameter int WIO = 7,
    parameter int WFO = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic signed [WI1+WF1-1:0]   data_in1,
    input  logic signed [WI2+WF2-1:0]   data_in2,
    output logic                        busy,
    output logic                        done,
    output logic signed [WIO+WFO-1:0]   data_out,
    output logic                        overflow,
    output logic                        div_by_zero
);

    localparam int N1   = WI1 + WF1;
    localparam int N2   = WI2 + WF2;
    localparam int NO   = WIO + WFO;
    localparam int SH   = WFO + WF2 - WF1;
    localparam int QW   = N1 + 1 + SH;
    localparam int CW   = QW + NO + 1;
    localparam int CNTW = $clog2(QW + 1);

    localparam logic [CW-1:0] MAXP = (CW'(1) << (NO - 1)) - CW'(1);
    localparam logic [CW-1:0] MINM = MAXP + CW'(1);
    localparam logic [NO-1:0] OMAX = {1'b0, {(NO-1){1'b1}}};
    localparam logic [NO-1:0] OMIN = {1'b1, {(NO-1){1'b0}}};

    if (WFO + WF2 < WF1) begin : g_bad_fmt
        $error("fixedpoint_divider: WFO+WF2 must be >= WF1");
    end

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state, state_nx;
    logic            sign_q, neg1_q, zero_q;
    logic [N2:0]     magb_q, rem_q, rem_nx;
    logic [QW-1:0]   d_q, quo_q, quo_nx;
    logic [CNTW-1:0] cnt_q;

    logic [N1:0]     mag_a;
    logic [N2:0]     mag_b;
    logic [N2+1:0]   rem_sh;
    logic            ge;
    logic [CW-1:0]   q_ext;
    logic [NO-1:0]   res;
    logic            res_ovf;
    logic            accept;

    // Magnitudes carry one extra bit so the most-negative operand is exact
    assign mag_a = data_in1[N1-1] ? -{data_in1[N1-1], data_in1}
                                  :  {data_in1[N1-1], data_in1};
    assign mag_b = data_in2[N2-1] ? -{data_in2[N2-1], data_in2}
                                  :  {data_in2[N2-1], data_in2};

    assign accept = (state == IDLE) && start;
    assign busy   = (state != IDLE);
    assign done   = (state == DONE);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = CALC;
            CALC:    if (cnt_q == CNTW'(1)) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        rem_sh = {rem_q, d_q[QW-1]};
        ge     = rem_sh >= {1'b0, magb_q};
        rem_nx = (N2+1)'(ge ? rem_sh - {1'b0, magb_q} : rem_sh);
        quo_nx = QW'({quo_q, ge});
        q_ext  = CW'(quo_nx);
    end

    // Saturate on the final magnitude; sign is applied afterwards
    always_comb begin
        res     = '0;
        res_ovf = 1'b0;
        if (!sign_q && q_ext > MAXP) begin
            res     = OMAX;
            res_ovf = 1'b1;
        end else if (sign_q && q_ext > MINM) begin
            res     = OMIN;
            res_ovf = 1'b1;
        end else if (sign_q) begin
            res = -q_ext[NO-1:0];
        end else begin
            res = q_ext[NO-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            sign_q      <= 1'b0;
            neg1_q      <= 1'b0;
            zero_q      <= 1'b0;
            magb_q      <= '0;
            rem_q       <= '0;
            d_q         <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            data_out    <= '0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                sign_q <= data_in1[N1-1] ^ data_in2[N2-1];
                neg1_q <= data_in1[N1-1];
                zero_q <= (mag_b == '0);
                magb_q <= mag_b;
                rem_q  <= '0;
                quo_q  <= '0;
                d_q    <= QW'(mag_a) << SH;
                cnt_q  <= CNTW'(QW);
            end else if (state == CALC) begin
                rem_q <= rem_nx;
                quo_q <= quo_nx;
                d_q   <= d_q << 1;
                cnt_q <= cnt_q - CNTW'(1);
                if (cnt_q == CNTW'(1)) begin
                    if (zero_q) begin
                        data_out    <= neg1_q ? OMIN : OMAX;
                        overflow    <= 1'b0;
                        div_by_zero <= 1'b1;
                    end else begin
                        data_out    <= res;
                        overflow    <= res_ovf;
                        div_by_zero <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_fixedpoint_divider.sv
// Bench for fixedpoint_divider: vector table, random model checks
// and hand sequences for abort, ignored start and back-to-back.
module tb_fixedpoint_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [8:0]  data_in1;
    logic [5:0]  data_in2;
    logic        busy, done, overflow, div_by_zero;
    logic [14:0] data_out;

    int passes = 0;
    int total  = 0;
    int cyc    = 0;

    typedef struct {
        logic [8:0]  a;
        logic [5:0]  b;
        logic [14:0] q;
        logic        ovf;
        logic        dbz;
    } vec_t;

    typedef struct {
        logic [14:0] q;
        logic        ovf;
        logic        dbz;
        int          acc;
    } sb_t;

    sb_t sb[$];

    fixedpoint_divider dut (
        .clk(clk), .rst(rst), .start(start),
        .data_in1(data_in1), .data_in2(data_in2),
        .busy(busy), .done(done), .data_out(data_out),
        .overflow(overflow), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Scoreboard side: every done pops one expected result
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                sb_t e;
                e = sb.pop_front();
                chk("data_out", {17'd0, data_out}, {17'd0, e.q});
                chk("overflow", {31'd0, overflow}, {31'd0, e.ovf});
                chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dbz});
                chk("latency", cyc - e.acc, 16);
            end
        end
    end

    function automatic sb_t model(logic [8:0] a, logic [5:0] b);
        int    av = $signed(a);
        int    bv = $signed(b);
        longint q;
        bit    s;
        sb_t   r;
        s     = (av < 0) != (bv < 0);
        r.ovf = 1'b0;
        r.dbz = 1'b0;
        r.acc = 0;
        if (bv == 0) begin
            r.dbz = 1'b1;
            r.q   = (av < 0) ? 15'h4000 : 15'h3FFF;
        end else begin
            q = (longint'(av < 0 ? -av : av) * 64) / (bv < 0 ? -bv : bv);
            if (!s && q > 16383) begin
                r.q = 15'h3FFF; r.ovf = 1'b1;
            end else if (s && q > 16384) begin
                r.q = 15'h4000; r.ovf = 1'b1;
            end else begin
                r.q = s ? 15'(-q) : 15'(q);
            end
        end
        return r;
    endfunction

    task automatic issue(logic [8:0] a, logic [5:0] b, bit push, sb_t e);
        @(negedge clk);
        data_in1 = a;
        data_in2 = b;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        data_in1 = 9'($urandom);
        data_in2 = 6'($urandom);
        e.acc    = cyc;
        if (push) sb.push_back(e);
        chk("busy_after_start", {31'd0, busy}, 1);
    endtask

    task automatic wait_done();
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!done && k < 40);
        if (!done) chk("done_timeout", 0, 1);
    endtask

    task automatic chk_zero(string nm);
        chk({nm, "_busy"}, {31'd0, busy}, 0);
        chk({nm, "_done"}, {31'd0, done}, 0);
        chk({nm, "_data_out"}, {17'd0, data_out}, 0);
        chk({nm, "_overflow"}, {31'd0, overflow}, 0);
        chk({nm, "_dbz"}, {31'd0, div_by_zero}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t vt[10];
        sb_t  e, e1, e2;
        vt[0] = '{9'd148,  6'd29,   15'd326,   1'b0, 1'b0};
        vt[1] = '{9'h16C,  6'd29,   15'h7EBA,  1'b0, 1'b0};
        vt[2] = '{9'h100,  6'h01,   15'h4000,  1'b0, 1'b0};
        vt[3] = '{9'h100,  6'h3F,   15'h3FFF,  1'b1, 1'b0};
        vt[4] = '{9'd32,   6'h00,   15'h3FFF,  1'b0, 1'b1};
        vt[5] = '{9'h1E0,  6'h00,   15'h4000,  1'b0, 1'b1};
        vt[6] = '{9'd0,    6'h3B,   15'd0,     1'b0, 1'b0};
        vt[7] = '{9'h1E0,  6'd8,    15'h7F00,  1'b0, 1'b0};
        vt[8] = '{9'd255,  6'h20,   15'h7E02,  1'b0, 1'b0};
        vt[9] = '{9'd1,    6'd31,   15'd2,     1'b0, 1'b0};

        rst = 1'b1; start = 1'b0; data_in1 = '0; data_in2 = '0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;

        foreach (vt[i]) begin
            e = '{vt[i].q, vt[i].ovf, vt[i].dbz, 0};
            issue(vt[i].a, vt[i].b, 1'b1, e);
            wait_done();
        end

        for (int i = 0; i < 20; i++) begin
            logic [8:0] a;
            logic [5:0] b;
            a = 9'($urandom);
            b = 6'($urandom);
            issue(a, b, 1'b1, model(a, b));
            wait_done();
        end

        // Start during a running division must be ignored
        e = model(9'd148, 6'd29);
        issue(9'd148, 6'd29, 1'b1, e);
        repeat (4) @(negedge clk);
        data_in1 = 9'd200; data_in2 = 6'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        repeat (20) @(negedge clk);
        chk("idle_after_ignored", {31'd0, busy}, 0);

        // Reset in cycle 8 aborts with no done pulse
        issue(9'h16C, 6'd5, 1'b0, e);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_zero("abort");
        rst = 1'b0;
        repeat (25) @(negedge clk);

        // Back-to-back: start held through DONE, accepted the cycle after
        e1 = model(9'd100, 6'd7);
        issue(9'd100, 6'd7, 1'b1, e1);
        wait_done();
        e2 = model(9'h190, 6'd3);
        data_in1 = 9'h190; data_in2 = 6'd3; start = 1'b1;
        @(negedge clk);
        chk("hold_idle", {17'd0, data_out}, {17'd0, e1.q});
        @(negedge clk);
        start = 1'b0;
        e2.acc = cyc;
        sb.push_back(e2);
        chk("b2b_busy", {31'd0, busy}, 1);
        repeat (8) @(negedge clk);
        chk("hold_mid", {17'd0, data_out}, {17'd0, e1.q});
        wait_done();
        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
